// File: rtl/scara_cmd_pkg.sv
// SCARA motion command definitions shared by the command issuer
// and the command interface.
package scara_cmd_pkg;

    typedef enum logic [2:0] {
        MOT_MOVE  = 3'b000,
        MOT_PICK  = 3'b001,
        MOT_PLACE = 3'b010,
        MOT_HOME  = 3'b011,
        MOT_STOP  = 3'b100
    } motion_e;

    localparam logic [7:0] CMD_MOVE  = 8'h04;
    localparam logic [7:0] CMD_PICK  = 8'h58;
    localparam logic [7:0] CMD_PLACE = 8'h5C;
    localparam logic [7:0] CMD_HOME  = 8'h50;
    localparam logic [7:0] CMD_STOP  = 8'h54;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/cmd_encoder.sv
// Maps a requested motion onto its command byte; codes 101-111
// come back flagged invalid.
module cmd_encoder
    import scara_cmd_pkg::*;
(
    input  logic [2:0] i_motion,
    output logic [7:0] o_code,
    output logic       o_valid
);

    always_comb begin
        o_code  = 8'h00;
        o_valid = 1'b1;
        case (i_motion)
            MOT_MOVE:  o_code = CMD_MOVE;
            MOT_PICK:  o_code = CMD_PICK;
            MOT_PLACE: o_code = CMD_PLACE;
            MOT_HOME:  o_code = CMD_HOME;
            MOT_STOP:  o_code = CMD_STOP;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/command_issuer_unit.sv
// Issues one encoded motion command per request, waits for its ack
// and resends on ack timeout up to MAX_RETRY times.
module command_issuer_unit
    import scara_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req_motion,
    input  logic        req_val,
    output logic        req_rdy,
    output logic [7:0]  cmd_data,
    output logic        cmd_val,
    input  logic        cmd_ack,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] cmd_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [1:0]    r_state;
    logic [7:0]    r_data;
    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_retry;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic [15:0]   r_count;

    logic [7:0]    w_code;
    logic          w_valid;

    cmd_encoder u_enc (
        .i_motion (req_motion),
        .o_code   (w_code),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_data     <= 8'h00;
            r_tmo      <= '0;
            r_retry    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_count    <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_val) begin
                        r_retry <= '0;
                        if (w_valid) begin
                            r_data  <= w_code;
                            r_state <= ST_SEND;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_INVALID;
                        end
                    end
                end
                ST_SEND: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack on the final timeout cycle still counts.
                    if (cmd_ack) begin
                        r_done  <= 1'b1;
                        r_count <= r_count + 16'd1;
                        r_state <= ST_IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        if (r_retry == RETRY_LAST) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= ST_SEND;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_rdy   = (r_state == ST_IDLE);
    assign cmd_val   = (r_state == ST_SEND);
    assign cmd_data  = r_data;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign cmd_count = r_count;

endmodule

// File: tb/tb_command_issuer_unit.sv
// Scoreboard bench for command_issuer_unit: expected command bytes are
// queued per attempt and popped whenever cmd_val is seen.
module tb_command_issuer_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_motion = 3'b000;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [7:0]  cmd_data;
    logic        cmd_val;
    logic        cmd_ack = 1'b0;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] cmd_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_count = 0;

    logic [7:0] exp_q[$];
    int t_val[$];
    int t_done[$];
    int t_err[$];

    bit ack_auto = 1'b1;
    bit ack_arm = 1'b0;
    int att_n = 0;
    int ack_from = 1;

    command_issuer_unit #(.ACK_TIMEOUT(15), .MAX_RETRY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_motion (req_motion),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .cmd_data   (cmd_data),
        .cmd_val    (cmd_val),
        .cmd_ack    (cmd_ack),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .cmd_count  (cmd_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every cmd_val pulse consumes one expected byte.
    initial forever begin
        logic [7:0] exp_b;
        @(negedge clock);
        if (cmd_val === 1'b1) begin
            t_val.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra_cmd got=%h want=none", cmd_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (cmd_data !== exp_b) begin
                    failures++;
                    $display("FAIL sb_cmd_data got=%h want=%h", cmd_data, exp_b);
                end
            end
        end
        if (done === 1'b1) t_done.push_back(cyc);
        if (err === 1'b1) t_err.push_back(cyc);
    end

    // Ack responder: acks during the WAIT cycle following a SEND,
    // starting from attempt number ack_from.
    initial forever begin
        @(negedge clock);
        if (ack_auto) begin
            cmd_ack = ack_arm;
            ack_arm = 1'b0;
            if (cmd_val === 1'b1) begin
                att_n++;
                ack_arm = (att_n >= ack_from);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_rec();
        t_val.delete();
        t_done.delete();
        t_err.delete();
        att_n = 0;
        ack_arm = 1'b0;
    endtask

    task automatic issue(input logic [2:0] m);
        @(negedge clock);
        req_motion = m;
        req_val = 1'b1;
        @(negedge clock);
        req_val = 1'b0;
    endtask

    task automatic wait_events(input int want, input int budget, output bit ok);
        int n = 0;
        while ((t_done.size() + t_err.size()) < want && n < budget) begin
            @(negedge clock);
            n++;
        end
        ok = ((t_done.size() + t_err.size()) >= want);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_val = 1'b0;
        cmd_ack = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (cmd_val !== 1'b0) begin failures++; $display("FAIL rst_cmd_val got=%b want=0", cmd_val); end
        checks++;
        if (cmd_data !== 8'h00) begin failures++; $display("FAIL rst_cmd_data got=%h want=00", cmd_data); end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b want=00", done, err); end
        checks++;
        if (err_code !== 2'b00) begin failures++; $display("FAIL rst_err_code got=%b want=00", err_code); end
        checks++;
        if (cmd_count !== 16'h0000) begin failures++; $display("FAIL rst_count got=%h want=0000", cmd_count); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_rdy !== 1'b1) begin failures++; $display("FAIL rst_req_rdy got=%b want=1", req_rdy); end
    endtask

    task automatic test_home();
        bit ok;
        clear_rec();
        ack_from = 1;
        exp_q.push_back(8'h50);
        issue(3'b011);
        wait_events(1, 40, ok);
        exp_count++;
        checks++;
        if (!ok) begin failures++; $display("FAIL home_timeout got=none want=done"); end
        checks++;
        if (t_val.size() != 1) begin failures++; $display("FAIL home_nval got=%0d want=1", t_val.size()); end
        checks++;
        if (t_done.size() != 1 || t_err.size() != 0) begin
            failures++; $display("FAIL home_pulses got=%0d/%0d want=1/0", t_done.size(), t_err.size());
        end else if (t_val.size() == 1) begin
            checks++;
            if (t_done[0] - t_val[0] != 2) begin
                failures++; $display("FAIL home_latency got=%0d want=2", t_done[0] - t_val[0]);
            end
        end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL home_count got=%h want=%h", cmd_count, 16'(exp_count)); end
        checks++;
        if (cmd_data !== 8'h50) begin failures++; $display("FAIL home_data_hold got=%h want=50", cmd_data); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL home_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_pick_retry();
        bit ok;
        int gap;
        clear_rec();
        ack_from = 2;
        exp_q.push_back(8'h58);
        exp_q.push_back(8'h58);
        issue(3'b001);
        wait_events(1, 80, ok);
        exp_count++;
        gap = (t_val.size() >= 2) ? t_val[1] - t_val[0] : -1;
        checks++;
        if (!ok) begin failures++; $display("FAIL pick_timeout got=none want=done"); end
        checks++;
        if (t_val.size() != 2) begin failures++; $display("FAIL pick_nval got=%0d want=2", t_val.size()); end
        checks++;
        if (gap != 16) begin failures++; $display("FAIL pick_gap got=%0d want=16", gap); end
        checks++;
        if (t_done.size() != 1 || t_err.size() != 0) begin
            failures++; $display("FAIL pick_pulses got=%0d/%0d want=1/0", t_done.size(), t_err.size());
        end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL pick_count got=%h want=%h", cmd_count, 16'(exp_count)); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL pick_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_stop_timeout();
        bit ok;
        int g1, g2, ge;
        clear_rec();
        ack_from = 99;
        repeat (3) exp_q.push_back(8'h54);
        issue(3'b100);
        wait_events(1, 120, ok);
        g1 = (t_val.size() >= 2) ? t_val[1] - t_val[0] : -1;
        g2 = (t_val.size() >= 3) ? t_val[2] - t_val[1] : -1;
        ge = (t_val.size() >= 3 && t_err.size() >= 1) ? t_err[0] - t_val[2] : -1;
        checks++;
        if (!ok) begin failures++; $display("FAIL stop_timeout got=none want=err"); end
        checks++;
        if (t_val.size() != 3) begin failures++; $display("FAIL stop_nval got=%0d want=3", t_val.size()); end
        checks++;
        if (g1 != 16 || g2 != 16) begin failures++; $display("FAIL stop_gaps got=%0d,%0d want=16,16", g1, g2); end
        checks++;
        if (ge != 16) begin failures++; $display("FAIL stop_err_latency got=%0d want=16", ge); end
        checks++;
        if (t_err.size() != 1 || t_done.size() != 0) begin
            failures++; $display("FAIL stop_pulses got=%0d/%0d want=0/1", t_done.size(), t_err.size());
        end
        checks++;
        if (err_code !== 2'b10) begin failures++; $display("FAIL stop_err_code got=%b want=10", err_code); end
        checks++;
        if (req_rdy !== 1'b1) begin failures++; $display("FAIL stop_req_rdy got=%b want=1", req_rdy); end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL stop_count got=%h want=%h", cmd_count, 16'(exp_count)); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stop_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_invalid();
        logic [2:0] bad[3] = '{3'b101, 3'b110, 3'b111};
        clear_rec();
        ack_from = 1;
        for (int i = 0; i < 3; i++) begin
            issue(bad[i]);
            checks++;
            if (err !== 1'b1) begin failures++; $display("FAIL inv_err m=%b got=%b want=1", bad[i], err); end
            checks++;
            if (err_code !== 2'b01) begin failures++; $display("FAIL inv_code m=%b got=%b want=01", bad[i], err_code); end
            checks++;
            if (cmd_val !== 1'b0 || req_rdy !== 1'b1) begin
                failures++; $display("FAIL inv_state m=%b got=%b%b want=01", bad[i], cmd_val, req_rdy);
            end
            @(negedge clock);
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL inv_pulse m=%b got=%b want=0", bad[i], err); end
        end
        checks++;
        if (t_val.size() != 0) begin failures++; $display("FAIL inv_nval got=%0d want=0", t_val.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        int gap;
        clear_rec();
        ack_from = 1;
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h5C);
        @(negedge clock);
        req_motion = 3'b000;
        req_val = 1'b1;
        @(negedge clock);
        req_motion = 3'b010;
        while (t_val.size() < 2 && n < 40) begin
            @(negedge clock);
            n++;
        end
        req_val = 1'b0;
        wait_events(2, 40, ok);
        exp_count += 2;
        gap = (t_val.size() >= 2 && t_done.size() >= 1) ? t_val[1] - t_done[0] : -1;
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout got=none want=2 done"); end
        checks++;
        if (t_val.size() != 2 || t_done.size() != 2) begin
            failures++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", t_val.size(), t_done.size());
        end
        checks++;
        if (gap != 1) begin failures++; $display("FAIL b2b_gap got=%0d want=1", gap); end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL b2b_count got=%h want=%h", cmd_count, 16'(exp_count)); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_stale_ack();
        int lat;
        clear_rec();
        ack_auto = 1'b0;
        cmd_ack = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (t_done.size() != 0 || cmd_count !== 16'(exp_count)) begin
            failures++; $display("FAIL stale_idle got=%0d/%h want=0/%h", t_done.size(), cmd_count, 16'(exp_count));
        end
        exp_q.push_back(8'h50);
        issue(3'b011);
        @(negedge clock);
        cmd_ack = 1'b0;
        @(negedge clock);
        cmd_ack = 1'b1;
        @(negedge clock);
        cmd_ack = 1'b0;
        repeat (2) @(negedge clock);
        exp_count++;
        lat = (t_val.size() == 1 && t_done.size() == 1) ? t_done[0] - t_val[0] : -1;
        checks++;
        if (lat != 3) begin failures++; $display("FAIL stale_latency got=%0d want=3", lat); end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL stale_count got=%h want=%h", cmd_count, 16'(exp_count)); end
        ack_auto = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        clear_rec();
        ack_from = 99;
        exp_q.push_back(8'h5C);
        issue(3'b010);
        repeat (4) @(negedge clock);
        clear_rec();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_count = 0;
        checks++;
        if (cmd_val !== 1'b0 || req_rdy !== 1'b1) begin
            failures++; $display("FAIL rw_state got=%b%b want=01", cmd_val, req_rdy);
        end
        checks++;
        if (cmd_data !== 8'h00) begin failures++; $display("FAIL rw_data got=%h want=00", cmd_data); end
        checks++;
        if (cmd_count !== 16'h0000) begin failures++; $display("FAIL rw_count got=%h want=0000", cmd_count); end
        repeat (20) @(negedge clock);
        checks++;
        if (t_val.size() + t_done.size() + t_err.size() != 0) begin
            failures++; $display("FAIL rw_quiet got=%0d/%0d/%0d want=0/0/0", t_val.size(), t_done.size(), t_err.size());
        end
        clear_rec();
        ack_from = 1;
        exp_q.push_back(8'h04);
        issue(3'b000);
        wait_events(1, 40, ok);
        exp_count++;
        checks++;
        if (!ok || t_done.size() != 1) begin failures++; $display("FAIL rw_move got=%0d want=1 done", t_done.size()); end
        checks++;
        if (cmd_data !== 8'h04) begin failures++; $display("FAIL rw_move_data got=%h want=04", cmd_data); end
        checks++;
        if (cmd_count !== 16'(exp_count)) begin failures++; $display("FAIL rw_move_count got=%h want=%h", cmd_count, 16'(exp_count)); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_rec();
        ack_from = 1;
        @(negedge clock);
        force dut.r_count = 16'hFFFF;
        @(negedge clock);
        release dut.r_count;
        exp_q.push_back(8'h50);
        issue(3'b011);
        wait_events(1, 40, ok);
        checks++;
        if (!ok || t_done.size() != 1) begin failures++; $display("FAIL wrap_done got=%0d want=1", t_done.size()); end
        checks++;
        if (cmd_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h want=0000", cmd_count); end
    endtask

    initial begin
        test_reset();
        test_home();
        test_pick_retry();
        test_stop_timeout();
        test_invalid();
        test_back_to_back();
        test_stale_ack();
        test_reset_in_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/command_issuer_unit.md
COMMAND_ISSUER_UNIT -- requirements
Module: command_issuer_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15: WAIT cycles without cmd_ack before one attempt is declared lost.
REQ-002 SHALL have parameter MAX_RETRY, default 2: resends allowed after the first attempt.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_motion  input  3  requested motion: 000 MOVE, 001 PICK, 010 PLACE, 011 HOME, 100 STOP; 101-111 invalid.
REQ-006 SHALL have port req_val  input  1  request valid.
REQ-007 SHALL have port req_rdy  output  1  issuer can accept a request.
REQ-008 SHALL have port cmd_data  output  8  encoded command byte to the command interface.
REQ-009 SHALL have port cmd_val  output  1  cmd_data valid, one-cycle pulse per attempt.
REQ-010 SHALL have port cmd_ack  input  1  acknowledge from the command interface.
REQ-011 SHALL have port done  output  1  one-cycle pulse on acknowledged command.
REQ-012 SHALL have port err  output  1  one-cycle pulse on failure.
REQ-013 SHALL have port err_code  output  2  01 invalid motion, 10 ack timeout; held until next err.
REQ-014 SHALL have port cmd_count  output  16  count of acknowledged commands, wraps FFFF->0000.

Function
REQ-015 SHALL encode MOVE=0x04, PICK=0x58, PLACE=0x5C, HOME=0x50, STOP=0x54.
REQ-016 SHALL implement states IDLE, SEND, WAIT; req_rdy=1 only in IDLE.
REQ-017 SHALL accept a request when req_val=1 and req_rdy=1 (cycle N), latching req_motion.
REQ-018 SHALL, for a valid accepted motion, enter SEND at N+1 with cmd_val=1 and cmd_data=code.
REQ-019 SHALL hold SEND exactly one cycle, then enter WAIT with timeout counter=0 and cmd_val=0.
REQ-020 SHALL hold cmd_data at the last sent code until the next SEND.
REQ-021 SHALL, when cmd_ack=1 in WAIT, go to IDLE next cycle with done=1 and cmd_count+1 (mod 2^16).
REQ-022 SHALL increment the timeout counter each WAIT cycle without cmd_ack; at count ACK_TIMEOUT-1 with cmd_ack=0 the attempt is lost.
REQ-023 SHALL, on a lost attempt with retries used < MAX_RETRY, re-enter SEND next cycle with the same code and increment the retry count.
REQ-024 SHALL, on a lost attempt with retries used = MAX_RETRY, go to IDLE with err=1, err_code=10; done and cmd_count unchanged.
REQ-025 SHALL, for an invalid accepted motion, stay in IDLE, not assert cmd_val, and pulse err=1, err_code=01 at N+1.
REQ-026 SHALL ignore cmd_ack in IDLE and SEND, including a stale ack.
REQ-027 SHALL ignore req_val while req_rdy=0; no queuing.
REQ-028 SHALL reset retry count to 0 on every accept.
REQ-029 SHALL allow back-to-back requests: accept at the done cycle, with SEND on the next cycle.

Reset
REQ-030 SHALL, while reset=0 at a clock edge, set state=IDLE, cmd_val=0, cmd_data=0x00, done=0, err=0, err_code=00, cmd_count=0, and counters=0.
REQ-031 SHALL have req_rdy=1 in the first cycle after reset release.
REQ-032 SHALL abort an in-flight attempt on reset in SEND or WAIT with no done or err pulse.

Structure
REQ-033 SHALL place the motion enumeration, the five command byte constants and the err_code values in the shared package scara_cmd_pkg, also used by the command interface.
REQ-034 SHALL use the combinational sub-module cmd_encoder: req_motion -> {code, valid}.

Verification
REQ-035 SHALL cover: HOME request, ack 1 cycle after cmd_val -> cmd_data=0x50 with one cmd_val pulse, done 2 cycles after SEND, cmd_count=1.
REQ-036 SHALL cover: PICK request, ack withheld first attempt, ack on second -> two cmd_val pulses 16 cycles apart (SEND+15 WAIT), one done, no err.
REQ-037 SHALL cover: STOP request, no ack ever -> 3 cmd_val pulses of 0x54, then err=1, err_code=10, req_rdy=1, cmd_count unchanged.
REQ-038 SHALL cover: req_motion=110 -> no cmd_val, err pulse next cycle, err_code=01, req_rdy stays 1.
REQ-039 SHALL cover: reset low during WAIT -> next cycle IDLE, cmd_data=0x00, no done or err; then a MOVE request -> 0x04 sent.
REQ-040 SHALL cover: cmd_count preset near wrap (65535 acked commands, or forced) -> next done gives cmd_count=0x0000.
